// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the LEGv8 register file
// write-port controller.
package regfile_pkg;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] XZR_ADDR = 5'd31;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

endpackage

// File: rtl/regfile_write_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the requester
// that wins the next contention (0 = A, 1 = B).
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // After a grant the other requester gets priority.
    always_comb begin
        ptr_d = ptr_q;
        if (advance && (|gnt)) ptr_d = gnt[0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) ptr_q <= 1'b0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Register file write-port owner: init sweep after reset, then
// round-robin write-back arbitration between ALU (A) and load (B).
module regfile_write_ctrl #(
    parameter int DATA_W    = regfile_pkg::DATA_W,
    parameter int ADDR_W    = regfile_pkg::ADDR_W,
    parameter int NUM_REGS  = regfile_pkg::NUM_REGS,
    parameter int INIT_MODE = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_add,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_add,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              write_en,
    output logic [ADDR_W-1:0] write_add,
    output logic [DATA_W-1:0] write_data,
    output logic              init_done,
    output logic              stall
);

    import regfile_pkg::*;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] XZR  = ADDR_W'(XZR_ADDR);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic              done_q, done_d;

    logic              run;
    logic [1:0]        req, gnt;
    logic [ADDR_W-1:0] g_add;
    logic [DATA_W-1:0] g_data;

    assign run = (state_q == ST_RUN);
    assign req = run ? {b_valid, a_valid} : 2'b00;

    rr_arb2 u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .advance (run),
        .gnt     (gnt)
    );

    assign a_ready = gnt[0];
    assign b_ready = gnt[1];
    assign g_add   = gnt[1] ? b_add  : a_add;
    assign g_data  = gnt[1] ? b_data : a_data;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        done_d  = done_q;
        unique case (state_q)
            ST_INIT: begin
                we_d  = 1'b1;
                wa_d  = cnt_q;
                wd_d  = (cnt_q == XZR || INIT_MODE == 0)
                      ? '0 : DATA_W'(cnt_q);
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end
            end
            ST_RUN: begin
                // XZR writes are accepted but never reach the file.
                if ((|gnt) && g_add != XZR) begin
                    we_d = 1'b1;
                    wa_d = g_add;
                    wd_d = g_data;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            done_q  <= done_d;
        end
    end

    assign write_en   = we_q;
    assign write_add  = wa_q;
    assign write_data = wd_q;
    assign init_done  = done_q;
    assign stall      = (a_valid && !a_ready)
                     || (b_valid && !b_ready)
                     || !done_q;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Bench for regfile_write_ctrl: init sweeps (both init modes), directed
// arbitration table, randomized traffic vs. a reference model, reset.
module tb_regfile_write_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        a_valid = 1'b0;
    logic [4:0]  a_add = '0;
    logic [63:0] a_data = '0;
    logic        b_valid = 1'b0;
    logic [4:0]  b_add = '0;
    logic [63:0] b_data = '0;
    logic        a_ready, b_ready, write_en, init_done, stall;
    logic [4:0]  write_add;
    logic [63:0] write_data;

    logic        a_ready2, b_ready2, we2, done2, stall2;
    logic [4:0]  wa2;
    logic [63:0] wd2;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    regfile_write_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .a_valid    (a_valid),
        .a_add      (a_add),
        .a_data     (a_data),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_add      (b_add),
        .b_data     (b_data),
        .b_ready    (b_ready),
        .write_en   (write_en),
        .write_add  (write_add),
        .write_data (write_data),
        .init_done  (init_done),
        .stall      (stall)
    );

    regfile_write_ctrl #(.INIT_MODE(0)) dut0 (
        .clock      (clock),
        .reset      (reset),
        .a_valid    (1'b0),
        .a_add      (5'd0),
        .a_data     (64'd0),
        .a_ready    (a_ready2),
        .b_valid    (1'b0),
        .b_add      (5'd0),
        .b_data     (64'd0),
        .b_ready    (b_ready2),
        .write_en   (we2),
        .write_add  (wa2),
        .write_data (wd2),
        .init_done  (done2),
        .stall      (stall2)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Requests (XZR target, harmless) stay valid during the sweep to
    // show the readies are held low; they drop before the last write.
    task automatic sweep(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            chk("init_we", 64'(write_en), 64'd1);
            chk("init_add", 64'(write_add), 64'(i));
            chk("init_data", write_data, (i == 31) ? 64'd0 : 64'(i));
            chk("init_done", 64'(init_done), 64'(i == 31));
            chk("init_stall", 64'(stall), 64'(i != 31));
            if (i < 31) begin
                chk("init_a_ready", 64'(a_ready), 64'd0);
                chk("init_b_ready", 64'(b_ready), 64'd0);
            end
            chk("m0_we", 64'(we2), 64'd1);
            chk("m0_add", 64'(wa2), 64'(i));
            chk("m0_data", wd2, 64'd0);
            chk("m0_done", 64'(done2), 64'(i == 31));
            @(posedge clock);
            #1;
            if (i >= 30) begin
                a_valid = 1'b0;
                b_valid = 1'b0;
            end
        end
    endtask

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [63:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [63:0] bd;
        logic        ar;
        logic        br;
        logic        st;
        logic        we;
        logic        cad;
        logic [4:0]  wa;
        logic [63:0] wd;
    } vec_t;

    vec_t tbl[12];

    // reference model state for random traffic
    bit          prio_a;
    bit          pa, pb, ga, gb;
    logic [4:0]  paa, pba, nadd;
    logic [63:0] pad, pbd, ndat;
    bit          exp_we;
    logic [4:0]  exp_add;
    logic [63:0] exp_data;

    initial begin
        tbl[0]  = '{1'b1, 5'd5, 64'hDEAD, 1'b0, 5'd0, 64'h0,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 64'h0};
        tbl[1]  = '{1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
                    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 64'hDEAD};
        tbl[2]  = '{1'b0, 5'd0, 64'h0, 1'b1, 5'd3, 64'h33,
                    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 64'hDEAD};
        tbl[3]  = '{1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22,
                    1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 64'h33};
        tbl[4]  = '{1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22,
                    1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd1, 64'h11};
        tbl[5]  = '{1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22,
                    1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 64'h22};
        tbl[6]  = '{1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22,
                    1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd1, 64'h11};
        tbl[7]  = '{1'b0, 5'd0, 64'h0, 1'b1, 5'd31, 64'h7,
                    1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 64'h22};
        tbl[8]  = '{1'b1, 5'd4, 64'h44, 1'b1, 5'd6, 64'h66,
                    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0};
        tbl[9]  = '{1'b0, 5'd0, 64'h0, 1'b1, 5'd6, 64'h66,
                    1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 64'h44};
        tbl[10] = '{1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
                    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 64'h66};
        tbl[11] = '{1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 64'h66};

        #2 reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_we", 64'(write_en), 64'd0);
        chk("rst_add", 64'(write_add), 64'd0);
        chk("rst_data", write_data, 64'd0);
        chk("rst_done", 64'(init_done), 64'd0);
        chk("rst_stall", 64'(stall), 64'd1);

        a_valid = 1'b1; a_add = 5'd31; a_data = 64'h5;
        b_valid = 1'b1; b_add = 5'd31; b_data = 64'h6;
        reset = 1'b0;
        sweep(32);

        for (int k = 0; k < 12; k++) begin
            a_valid = tbl[k].av; a_add = tbl[k].aa; a_data = tbl[k].ad;
            b_valid = tbl[k].bv; b_add = tbl[k].ba; b_data = tbl[k].bd;
            @(negedge clock);
            chk($sformatf("t%0d_a_ready", k), 64'(a_ready), 64'(tbl[k].ar));
            chk($sformatf("t%0d_b_ready", k), 64'(b_ready), 64'(tbl[k].br));
            chk($sformatf("t%0d_stall", k), 64'(stall), 64'(tbl[k].st));
            chk($sformatf("t%0d_we", k), 64'(write_en), 64'(tbl[k].we));
            if (tbl[k].cad) begin
                chk($sformatf("t%0d_add", k), 64'(write_add),
                    64'(tbl[k].wa));
                chk($sformatf("t%0d_data", k), write_data, tbl[k].wd);
            end
            @(posedge clock);
            #1;
        end

        // Model: the requester not granted last wins a contention.
        prio_a = 1'b1;
        pa = 1'b0; pb = 1'b0;
        exp_we = 1'b0; exp_add = 5'd6; exp_data = 64'h66;
        for (int n = 0; n < 400; n++) begin
            if (!pa && $urandom_range(1) == 1) begin
                pa  = 1'b1;
                paa = ($urandom_range(3) == 0) ? 5'd31
                                               : 5'($urandom_range(30));
                pad = {$urandom(), $urandom()};
            end
            if (!pb && $urandom_range(1) == 1) begin
                pb  = 1'b1;
                pba = ($urandom_range(3) == 0) ? 5'd31
                                               : 5'($urandom_range(30));
                pbd = {$urandom(), $urandom()};
            end
            a_valid = pa; a_add = paa; a_data = pad;
            b_valid = pb; b_add = pba; b_data = pbd;
            @(negedge clock);
            ga = pa && (!pb || prio_a);
            gb = pb && !ga;
            chk("rnd_a_ready", 64'(a_ready), 64'(ga));
            chk("rnd_b_ready", 64'(b_ready), 64'(gb));
            chk("rnd_stall", 64'(stall), 64'((pa && !ga) || (pb && !gb)));
            chk("rnd_we", 64'(write_en), 64'(exp_we));
            if (exp_we) begin
                chk("rnd_add", 64'(write_add), 64'(exp_add));
                chk("rnd_data", write_data, exp_data);
            end
            if (ga || gb) begin
                nadd   = ga ? paa : pba;
                ndat   = ga ? pad : pbd;
                exp_we = (nadd != 5'd31);
                if (exp_we) begin
                    exp_add  = nadd;
                    exp_data = ndat;
                end
                prio_a = gb;
                if (ga) pa = 1'b0;
                else    pb = 1'b0;
            end else begin
                exp_we = 1'b0;
            end
            @(posedge clock);
            #1;
        end

        // Reset in the middle of a sweep with A requesting.
        a_valid = 1'b1; a_add = 5'd9; a_data = 64'h99;
        b_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        sweep(10);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("mid_rst_we", 64'(write_en), 64'd0);
        chk("mid_rst_add", 64'(write_add), 64'd0);
        chk("mid_rst_data", write_data, 64'd0);
        chk("mid_rst_done", 64'(init_done), 64'd0);
        chk("mid_rst_a_ready", 64'(a_ready), 64'd0);
        chk("mid_rst_stall", 64'(stall), 64'd1);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        sweep(32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
